// File: rtl/over_screen_ctrl.sv
// over_screen_ctrl: sequences the "game over" banner.
// Runs hide/slide-in/show, drives the banner origin once per frame,
// issues BRAM prefetch addresses ahead of the beam and flags banner pixels.
module over_screen_ctrl #(
  parameter int SPR_W        = 320,
  parameter int SPR_H        = 64,
  parameter int X_POS        = 160,
  parameter int START_Y      = 480,
  parameter int TARGET_Y     = 208,
  parameter int STEP         = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int BRAM_LAT     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        game_over,
  input  logic        restart,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [9:0]  OverX,
  output logic [9:0]  OverY,
  output logic [11:0] over_addr,
  output logic        over_rd_en,
  output logic        over_hit,
  output logic        busy
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0] X_LO   = 11'(X_POS);
  localparam logic [10:0] X_HI   = 11'(X_POS + SPR_W);
  localparam logic [10:0] Y_STOP = 11'(TARGET_Y + STEP);

  typedef enum logic [1:0] {
    IDLE,
    SLIDE,
    SHOW
  } state_t;

  state_t        state, state_nx;
  logic [9:0]    over_y, over_y_nx;
  logic [CW-1:0] blink_cnt, blink_cnt_nx;
  logic          blank, blank_nx;

  // Banner state register; reset returns everything to the hidden banner.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      over_y    <= 10'(START_Y);
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else begin
      state     <= state_nx;
      over_y    <= over_y_nx;
      blink_cnt <= blink_cnt_nx;
      blank     <= blank_nx;
    end
  end

  // Next-state logic: restart beats everything; origin only moves on frame_start.
  always_comb begin
    state_nx     = state;
    over_y_nx    = over_y;
    blink_cnt_nx = blink_cnt;
    blank_nx     = blank;
    if (restart && state != IDLE) begin
      state_nx     = IDLE;
      over_y_nx    = 10'(START_Y);
      blink_cnt_nx = '0;
      blank_nx     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (game_over && !restart) state_nx = SLIDE;
        end
        SLIDE: begin
          if (frame_start) begin
            // Clamp at the target and enter SHOW on the same frame the target is reached.
            if ({1'b0, over_y} <= Y_STOP) begin
              over_y_nx = 10'(TARGET_Y);
              state_nx  = SHOW;
            end else begin
              over_y_nx = over_y - 10'(STEP);
            end
          end
        end
        SHOW: begin
          if (frame_start && BLINK_FRAMES != 0) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
              blink_cnt_nx = '0;
              blank_nx     = ~blank;
            end else begin
              blink_cnt_nx = blink_cnt + 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  logic [10:0] xl, xd, y11, oy11, xoff;
  logic        y_in, xl_in, xd_in;
  logic [9:0]  row;
  logic [11:0] row12, word_addr;

  // Window tests and prefetch address; xl looks BRAM_LAT pixels ahead of the beam.
  always_comb begin
    xl        = {1'b0, DrawX} + 11'(BRAM_LAT);
    xd        = {1'b0, DrawX};
    y11       = {1'b0, DrawY};
    oy11      = {1'b0, over_y};
    y_in      = (y11 >= oy11) && (y11 < oy11 + 11'(SPR_H));
    xl_in     = (xl >= X_LO) && (xl < X_HI);
    xd_in     = (xd >= X_LO) && (xd < X_HI);
    row       = DrawY - over_y;
    row12     = {2'b00, row};
    xoff      = xl - X_LO;
    word_addr = (row12 << 5) + (row12 << 3) + 12'(xoff >> 3);
  end

  assign busy       = (state != IDLE);
  assign OverX      = 10'(X_POS);
  assign OverY      = over_y;
  assign over_rd_en = busy && xl_in && y_in;
  assign over_addr  = over_rd_en ? word_addr : '0;
  assign over_hit   = busy && !blank && xd_in && y_in;

endmodule

// File: tb/tb_over_screen_ctrl.sv
// Randomised bench for over_screen_ctrl against a frame-count based model.
module tb_over_screen_ctrl;

  localparam int START_Y  = 480;
  localparam int TARGET_Y = 208;
  localparam int X_POS    = 160;
  localparam int SPR_W    = 320;
  localparam int SPR_H    = 64;
  localparam int LAT      = 2;
  localparam int BLINK    = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_over = 1'b0;
  logic        restart = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  draw_x = '0;
  logic [9:0]  draw_y = '0;

  logic [9:0]  over_x, over_y;
  logic [11:0] over_addr;
  logic        over_rd_en, over_hit, busy;

  logic [9:0]  over_x5, over_y5;
  logic [11:0] over_addr5;
  logic        over_rd_en5, over_hit5, busy5;

  int checks = 0;
  int errors = 0;
  bit active = 0;
  int n = 0;

  over_screen_ctrl dut (
    .Clk(clk), .Reset(rst), .game_over(game_over), .restart(restart),
    .frame_start(frame_start), .DrawX(draw_x), .DrawY(draw_y),
    .OverX(over_x), .OverY(over_y), .over_addr(over_addr),
    .over_rd_en(over_rd_en), .over_hit(over_hit), .busy(busy)
  );

  over_screen_ctrl #(.STEP(5)) dut5 (
    .Clk(clk), .Reset(rst), .game_over(game_over), .restart(restart),
    .frame_start(frame_start), .DrawX(draw_x), .DrawY(draw_y),
    .OverX(over_x5), .OverY(over_y5), .over_addr(over_addr5),
    .over_rd_en(over_rd_en5), .over_hit(over_hit5), .busy(busy5)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int exp_y(int frames, int step);
    int y;
    if (!active) return START_Y;
    y = START_Y - step * frames;
    if (y < TARGET_Y) y = TARGET_Y;
    return y;
  endfunction

  function automatic bit exp_vis(int frames);
    int f;
    f = (START_Y - TARGET_Y + 3) / 4;
    if (frames <= f) return 1'b1;
    return ((frames - f) / BLINK) % 2 == 0;
  endfunction

  function automatic bit in_win(int x, int y, int oy);
    return x >= X_POS && x < X_POS + SPR_W && y >= oy && y < oy + SPR_H;
  endfunction

  function automatic bit exp_hit(int x, int y);
    return active && exp_vis(n) && in_win(x, y, exp_y(n, 4));
  endfunction

  function automatic bit exp_rd(int x, int y);
    return active && in_win(x + LAT, y, exp_y(n, 4));
  endfunction

  function automatic int exp_addr(int x, int y);
    if (!exp_rd(x, y)) return 0;
    return (y - exp_y(n, 4)) * (SPR_W / 8) + (x + LAT - X_POS) / 8;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    if (active) n++;
  endtask

  task automatic pulse_game_over();
    @(negedge clk) game_over = 1'b1;
    @(negedge clk) game_over = 1'b0;
    if (!active) begin
      active = 1;
      n = 0;
    end
  endtask

  task automatic set_pixel(int x, int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    set_pixel(200, 500);
    checks++; if (over_x !== 10'd160) begin errors++; $display("FAIL reset_overx got=%0d exp=160", over_x); end
    checks++; if (over_y !== 10'd480) begin errors++; $display("FAIL reset_overy got=%0d exp=480", over_y); end
    checks++; if (over_addr !== 12'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", over_addr); end
    checks++; if (over_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", over_rd_en); end
    checks++; if (over_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0", over_hit); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_slide();
    repeat (5) @(negedge clk);
    pulse_game_over();
    repeat (3) @(negedge clk);
    checks++; if (over_y !== 10'd480) begin errors++; $display("FAIL slide_hold got=%0d exp=480", over_y); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL slide_busy0 got=%b exp=1", busy); end
    for (int f = 1; f <= 75; f++) begin
      if (f == 10) pulse_game_over();
      do_frame();
      #1;
      checks++;
      if (over_y !== 10'(exp_y(n, 4))) begin
        errors++; $display("FAIL slide_y frame=%0d got=%0d exp=%0d", n, over_y, exp_y(n, 4));
      end
      checks++;
      if (over_y5 !== 10'(exp_y(n, 5))) begin
        errors++; $display("FAIL slide5_y frame=%0d got=%0d exp=%0d", n, over_y5, exp_y(n, 5));
      end
      checks++;
      if (busy !== 1'b1 || busy5 !== 1'b1) begin
        errors++; $display("FAIL slide_busy frame=%0d got=%b%b exp=11", n, busy, busy5);
      end
    end
  endtask

  task automatic test_addr();
    int xs[4]  = '{158, 166, 477, 478};
    int as[4]  = '{80, 81, 119, 0};
    bit rds[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int x, y;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) set_pixel(xs[i], 210);
      checks++;
      if (over_addr !== 12'(as[i]) || over_rd_en !== rds[i]) begin
        errors++;
        $display("FAIL addr_directed x=%0d got=%0d/%b exp=%0d/%b", xs[i], over_addr, over_rd_en, as[i], rds[i]);
      end
    end
    for (int i = 0; i < 200; i++) begin
      x = $urandom_range(140, 490);
      y = $urandom_range(195, 285);
      @(negedge clk) set_pixel(x, y);
      checks++;
      if (over_addr !== 12'(exp_addr(x, y)) || over_rd_en !== exp_rd(x, y) || over_hit !== exp_hit(x, y)) begin
        errors++;
        $display("FAIL addr_random x=%0d y=%0d got=%0d/%b/%b exp=%0d/%b/%b", x, y,
                 over_addr, over_rd_en, over_hit, exp_addr(x, y), exp_rd(x, y), exp_hit(x, y));
      end
    end
  endtask

  task automatic test_blink();
    int x, y;
    for (int f = 0; f < 60; f++) begin
      do_frame();
      for (int k = 0; k < 3; k++) begin
        x = (k == 0) ? 300 : $urandom_range(150, 490);
        y = (k == 0) ? 240 : $urandom_range(200, 280);
        set_pixel(x, y);
        checks++;
        if (over_hit !== exp_hit(x, y)) begin
          errors++;
          $display("FAIL blink_hit frame=%0d x=%0d y=%0d got=%b exp=%b", n, x, y, over_hit, exp_hit(x, y));
        end
      end
    end
  endtask

  task automatic test_restart();
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    active = 0;
    set_pixel(300, 500);
    checks++;
    if (over_y !== 10'd480 || busy !== 1'b0 || over_hit !== 1'b0) begin
      errors++; $display("FAIL restart_show got=%0d/%b/%b exp=480/0/0", over_y, busy, over_hit);
    end
    pulse_game_over();
    for (int f = 0; f < 20; f++) do_frame();
    #1;
    checks++;
    if (over_y !== 10'(exp_y(n, 4))) begin
      errors++; $display("FAIL restart_slide got=%0d exp=%0d", over_y, exp_y(n, 4));
    end
    @(negedge clk) begin restart = 1'b1; game_over = 1'b1; end
    @(negedge clk) begin restart = 1'b0; game_over = 1'b0; end
    active = 0;
    set_pixel(300, 500);
    checks++;
    if (over_y !== 10'd480 || over_hit !== 1'b0 || busy !== 1'b0 || busy5 !== 1'b0 || over_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL restart_both got=%0d/%b/%b/%b/%b exp=480/0/0/0/0", over_y, over_hit, busy, busy5, over_rd_en);
    end
    for (int f = 0; f < 3; f++) do_frame();
    #1;
    checks++;
    if (over_y !== 10'd480 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_hold got=%0d/%b exp=480/0", over_y, busy);
    end
  endtask

  task automatic test_async_reset();
    pulse_game_over();
    for (int f = 0; f < 70; f++) do_frame();
    @(negedge clk) set_pixel(300, 250);
    checks++;
    if (over_hit !== exp_hit(300, 250) || over_addr !== 12'(exp_addr(300, 250))) begin
      errors++;
      $display("FAIL pre_reset got=%b/%0d exp=%b/%0d", over_hit, over_addr, exp_hit(300, 250), exp_addr(300, 250));
    end
    #1 rst = 1'b1;
    #1;
    active = 0;
    checks++;
    if (over_y !== 10'd480 || over_x !== 10'd160 || over_addr !== 12'd0 ||
        over_rd_en !== 1'b0 || over_hit !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got=%0d/%0d/%0d/%b/%b/%b exp=480/160/0/0/0/0",
               over_y, over_x, over_addr, over_rd_en, over_hit, busy);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_slide();
    test_addr();
    test_blink();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
